// File: rtl/init_store_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | init_store_pkg : shared encodings and entry layout for init_cmd_store    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package init_store_pkg;

  typedef enum logic [1:0] {
    ST_NONE   = 2'd0,
    ST_END    = 2'd1,
    ST_RANOUT = 2'd2,
    ST_ABORT  = 2'd3
  } status_e;

  localparam logic [23:0] DEF_END_CODE = 24'hFF_FFFF;

  // Field positions of a default-width {dev, reg, val} entry
  localparam int DEV_HI = 23;
  localparam int DEV_LO = 16;
  localparam int REG_HI = 15;
  localparam int REG_LO = 8;
  localparam int VAL_HI = 7;
  localparam int VAL_LO = 0;

endpackage
`default_nettype wire

// File: rtl/ram_sdp_init.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_sdp_init : block RAM, port A read/write, port B read-only            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ram_sdp_init #(
  parameter int DATA_W    = 24,
  parameter int ADDR_W    = 6,
  parameter     INIT_FILE = "adv7611.mif"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_en_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  output logic [DATA_W-1:0] b_rdata_o
);

  (* ramstyle = "M9K", ram_init_file = INIT_FILE *)
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  // Contents are loaded by the device programming image, not by reset logic
  if (INIT_FILE != "") begin : g_init_image
  end

  always_ff @(posedge clk) begin
    if (a_we_i) begin
      mem_q[a_addr_i] <= a_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata_q <= '0;
    end else begin
      a_rdata_q <= mem_q[a_addr_i];
    end
  end

  always_ff @(posedge clk) begin
    if (b_en_i) begin
      b_rdata_q <= mem_q[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule
`default_nettype wire

// File: rtl/init_cmd_store.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | init_cmd_store : I2C init command list with host port and stream port    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module init_cmd_store
  import init_store_pkg::*;
#(
  parameter int                DATA_W    = 24,
  parameter int                ADDR_W    = 6,
  parameter                    INIT_FILE = "adv7611.mif",
  parameter logic [DATA_W-1:0] END_CODE  = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [ADDR_W:0]   count,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic              infl_q, infl_d;
  logic              infl_last_q, infl_last_d;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] slot0_q, slot0_d;
  logic [DATA_W-1:0] slot1_q, slot1_d;
  logic [ADDR_W:0]   count_q, count_d;
  status_e           status_q, status_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] rd_data;
  logic              pop, ret_valid, ret_end, push, issue;
  logic [1:0]        occ_after_pop;
  logic [2:0]        credit;

  ram_sdp_init #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .a_we_i   (host_we),
    .a_addr_i (host_addr),
    .a_wdata_i(host_wdata),
    .a_rdata_o(host_rdata),
    .b_en_i   (issue),
    .b_addr_i (ptr_q[ADDR_W-1:0]),
    .b_rdata_o(rd_data)
  );

  always_comb begin
    pop           = (occ_q != 2'd0) && m_ready;
    ret_valid     = infl_q && (state_q == S_RUN);
    ret_end       = ret_valid && (rd_data == END_CODE);
    push          = ret_valid && !ret_end;
    occ_after_pop = occ_q - {1'b0, pop};
    // Slots already promised: stored entries plus the word still in the RAM
    credit        = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
    issue         = (state_q == S_RUN) && !ptr_q[ADDR_W] && !ret_end && !abort
                    && (credit < 3'd2);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    infl_d      = 1'b0;
    infl_last_d = 1'b0;
    occ_d       = occ_q + {1'b0, push} - {1'b0, pop};
    slot0_d     = slot0_q;
    slot1_d     = slot1_q;
    count_d     = count_q + {{ADDR_W{1'b0}}, pop};
    status_d    = status_q;
    done_d      = 1'b0;

    if (pop) begin
      slot0_d = slot1_q;
    end
    if (push) begin
      if (occ_after_pop == 2'd0) begin
        slot0_d = rd_data;
      end else begin
        slot1_d = rd_data;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d  = S_RUN;
          ptr_d    = {1'b0, start_addr};
          count_d  = '0;
          status_d = ST_NONE;
          occ_d    = 2'd0;
        end
      end
      S_RUN: begin
        infl_d      = issue;
        infl_last_d = issue && (ptr_q[ADDR_W-1:0] == {ADDR_W{1'b1}});
        if (issue) begin
          ptr_d = ptr_q + 1'b1;
        end
        if (ret_end) begin
          state_d  = S_DRAIN;
          status_d = ST_END;
        end else if (ret_valid && infl_last_q) begin
          state_d  = S_DRAIN;
          status_d = ST_RANOUT;
        end
      end
      S_DRAIN: begin
        if (occ_q == 2'd0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      occ_d    = 2'd0;
      infl_d   = 1'b0;
      status_d = ST_ABORT;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      occ_q       <= 2'd0;
      slot0_q     <= '0;
      slot1_q     <= '0;
      count_q     <= '0;
      status_q    <= ST_NONE;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      occ_q       <= occ_d;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      count_q     <= count_d;
      status_q    <= status_d;
      done_q      <= done_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign status  = status_q;
  assign count   = count_q;
  assign m_valid = (occ_q != 2'd0);
  assign m_data  = slot0_q;

endmodule
`default_nettype wire

// File: tb/tb_init_cmd_store.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_init_cmd_store : directed self-checking bench for init_cmd_store      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_init_cmd_store;
  import init_store_pkg::*;

  logic        clk;
  logic        rst;
  logic        host_we;
  logic [5:0]  host_addr;
  logic [23:0] host_wdata;
  logic [23:0] host_rdata;
  logic        start;
  logic [5:0]  start_addr;
  logic        abort;
  logic        busy;
  logic        done;
  logic [1:0]  status;
  logic [6:0]  count;
  logic        m_valid;
  logic [23:0] m_data;
  logic        m_ready;

  int n_chk  = 0;
  int n_pass = 0;

  logic [23:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [23:0] wdata;
    logic        chk_en;
    logic [23:0] exp;
  } hvec_t;

  hvec_t tbl[16];

  init_cmd_store u_dut (
    .clk       (clk),
    .rst       (rst),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .start     (start),
    .start_addr(start_addr),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .status    (status),
    .count     (count),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start_stream(input logic [5:0] sa);
    start      = 1'b1;
    start_addr = sa;
    tick();
    start      = 1'b0;
  endtask

  task automatic load_list();
    exp_q = {24'h981001, 24'h981002, 24'h981003, 24'h981004};
  endtask

  // Drives m_ready from a repeating 4-cycle pattern until done or budget
  task automatic collect(input logic [3:0] pat, input logic [1:0] exp_st,
                         input int exp_cnt, output int span);
    int          beats;
    int          first_cyc;
    int          last_cyc;
    bit          seen_done;
    logic        stall;
    logic [23:0] held;
    beats     = 0;
    first_cyc = -1;
    last_cyc  = -1;
    seen_done = 1'b0;
    stall     = 1'b0;
    held      = '0;
    for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
      m_ready = pat[cyc % 4];
      if (stall) begin
        chk("stall_valid_held", m_valid, 1);
        chk("stall_data_held", m_data, held);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() != 0) chk("beat_data", m_data, exp_q.pop_front());
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        beats++;
      end
      stall = m_valid && !m_ready;
      held  = m_data;
      tick();
      if (done) begin
        seen_done = 1'b1;
        chk("done_busy_low", busy, 0);
      end
    end
    m_ready = 1'b0;
    chk("done_seen", seen_done, 1);
    chk("beats", beats, exp_cnt);
    chk("count", count, exp_cnt);
    chk("status", status, exp_st);
    span = last_cyc - first_cyc;
  endtask

  initial begin
    int span;
    rst        = 1'b1;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    start      = 1'b0;
    start_addr = '0;
    abort      = 1'b0;
    m_ready    = 1'b0;

    tbl[0]  = '{1'b1, 6'd5,  24'hABCDEF, 1'b0, 24'h0};
    tbl[1]  = '{1'b0, 6'd5,  24'h0,      1'b1, 24'hABCDEF};
    tbl[2]  = '{1'b1, 6'd5,  24'h123456, 1'b1, 24'hABCDEF};
    tbl[3]  = '{1'b0, 6'd5,  24'h0,      1'b1, 24'h123456};
    tbl[4]  = '{1'b1, 6'd5,  24'hABCDEF, 1'b1, 24'h123456};
    tbl[5]  = '{1'b0, 6'd5,  24'h0,      1'b1, 24'hABCDEF};
    tbl[6]  = '{1'b1, 6'd0,  24'h981001, 1'b0, 24'h0};
    tbl[7]  = '{1'b1, 6'd1,  24'h981002, 1'b0, 24'h0};
    tbl[8]  = '{1'b1, 6'd2,  24'h981003, 1'b0, 24'h0};
    tbl[9]  = '{1'b1, 6'd3,  24'h981004, 1'b0, 24'h0};
    tbl[10] = '{1'b1, 6'd4,  DEF_END_CODE, 1'b0, 24'h0};
    tbl[11] = '{1'b1, 6'd62, 24'h55AA01, 1'b0, 24'h0};
    tbl[12] = '{1'b1, 6'd63, 24'h55AA02, 1'b0, 24'h0};
    tbl[13] = '{1'b0, 6'd0,  24'h0,      1'b1, 24'h981001};
    tbl[14] = '{1'b0, 6'd4,  24'h0,      1'b1, DEF_END_CODE};
    tbl[15] = '{1'b0, 6'd63, 24'h0,      1'b1, 24'h55AA02};

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_status", status, ST_NONE);
    chk("rst_count", count, 0);
    chk("rst_rdata", host_rdata, 0);

    // Host port: latency 1, old data on same-edge read-during-write
    for (int i = 0; i < 16; i++) begin
      host_we    = tbl[i].we;
      host_addr  = tbl[i].addr;
      host_wdata = tbl[i].wdata;
      tick();
      if (tbl[i].chk_en) chk("host_rdata", host_rdata, tbl[i].exp);
    end
    host_we = 1'b0;

    // Full-rate stream with first-beat latency
    m_ready = 1'b1;
    load_list();
    start_stream(6'd0);
    chk("a_busy_k", busy, 1);
    chk("a_valid_k", m_valid, 0);
    tick();
    chk("a_valid_k1", m_valid, 0);
    tick();
    chk("a_valid_k2", m_valid, 1);
    chk("a_dev_field", m_data[DEV_HI:DEV_LO], 8'h98);
    chk("a_val_field", m_data[VAL_HI:VAL_LO], 8'h01);
    collect(4'b1111, ST_END, 4, span);
    chk("a_back_to_back", span, 3);

    // Stalling sequencer
    load_list();
    start_stream(6'd0);
    collect(4'b1001, ST_END, 4, span);

    // Run off the top of memory
    exp_q = {24'h55AA01, 24'h55AA02};
    start_stream(6'd62);
    collect(4'b1111, ST_RANOUT, 2, span);

    // Empty list: END_CODE at the start address
    m_ready = 1'b1;
    start_stream(6'd4);
    chk("e_busy_k", busy, 1);
    tick();
    chk("e_valid_k1", m_valid, 0);
    tick();
    chk("e_valid_k2", m_valid, 0);
    chk("e_done_k2", done, 0);
    tick();
    chk("e_done_k3", done, 1);
    chk("e_busy_k3", busy, 0);
    chk("e_count", count, 0);
    chk("e_status", status, ST_END);
    m_ready = 1'b0;

    // Abort with the sequencer stalled, then restart
    start_stream(6'd0);
    tick();
    tick();
    chk("ab_first_beat", m_valid, 1);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_valid", m_valid, 0);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 1);
    chk("ab_status", status, ST_ABORT);
    tick();
    chk("ab_done_pulse", done, 0);
    load_list();
    start_stream(6'd0);
    collect(4'b1111, ST_END, 4, span);

    // start with abort while idle does nothing
    start      = 1'b1;
    abort      = 1'b1;
    start_addr = 6'd0;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_status", status, ST_END);
    chk("sa_done", done, 0);

    // Reset in the middle of a stream; RAM contents survive
    start_stream(6'd0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_valid", m_valid, 0);
    chk("mr_data", m_data, 0);
    chk("mr_status", status, ST_NONE);
    chk("mr_count", count, 0);
    chk("mr_rdata", host_rdata, 0);
    rst       = 1'b0;
    host_addr = 6'd1;
    tick();
    chk("mr_done_after", done, 0);
    chk("mr_ram_kept", host_rdata, 24'h981002);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/init_cmd_store.md
# init_cmd_store

Parametrised successor to the fixed 64×24 initialisation RAM. It holds the I2C command list for a video-receiver bring-up: width, depth and initialisation file are parameters. A host read/write port is kept for patching entries at run time. A new streaming port walks the list from a start address and presents entries on a valid/ready interface to the I2C sequencer. The walk stops at an end-of-list code, at the top of memory, or on abort.

## Interface
- DATA_W, 24: entry width; entry format {dev[23:16], reg[15:8], val[7:0]} at default width.
- ADDR_W, 6: address width; depth is 2**ADDR_W.
- INIT_FILE, "adv7611.mif": memory initialisation file.
- END_CODE, all-ones of DATA_W: entry value that terminates a stream.
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high. Clears all stream state and host_rdata. RAM contents are not cleared.
- host_we  in  1  write strobe.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  write data.
- host_rdata  out  DATA_W  registered read data; reset 0.
- start  in  1  begin stream (pulse).
- start_addr  in  ADDR_W  first entry to stream.
- abort  in  1  cancel stream.
- busy  out  1  stream active; reset 0.
- done  out  1  one-cycle pulse at stream end; reset 0.
- status  out  2  0 NONE, 1 END, 2 RANOUT, 3 ABORT; reset NONE; held until next accepted start.
- count  out  ADDR_W+1  entries handed over in the current or last stream; reset 0.
- m_valid  out  1  entry available; reset 0.
- m_data  out  DATA_W  entry; reset 0.
- m_ready  in  1  sequencer accepts.

## Operation
- Host port:
  - Read latency is 1: host_rdata is updated at the edge after host_addr is presented.
  - Same-port read-during-write returns the old data.
- Stream port:
  - Dedicated read port with a separate stream pointer `ptr`.
  - Feeds a 2-entry output FIFO, whose head drives m_data/m_valid.
- State machine has three states: IDLE, RUN, DRAIN.
  - IDLE → RUN on start && !abort. On that transition: ptr←start_addr, count←0, status←NONE, busy←1.
  - RUN, read issue rule: issue a read of mem[ptr] when FIFO occupancy + in-flight − pop < 2, then increment ptr.
  - RUN, top of memory: after issuing address 2**ADDR_W−1, no further reads; there is no wrap-around.
  - RUN, returned word == END_CODE: the word is not pushed; any in-flight read behind it is discarded. Go to DRAIN with status END.
  - RUN, last address returned without END_CODE: go to DRAIN with status RANOUT.
  - DRAIN → IDLE when the FIFO is empty. On that transition: done pulse, busy←0.
  - abort in RUN or DRAIN: flush the FIFO, discard in-flight reads, status←ABORT, done pulse, go to IDLE on the next edge.
- Handshake:
  - A transfer occurs when m_valid && m_ready; count increments on each transfer.
  - While m_valid && !m_ready, m_data is held stable.
  - m_valid never drops without a transfer, except on abort or rst.
- Simultaneous events:
  - start while busy: ignored.
  - start && abort while IDLE: abort wins and nothing happens; status is unchanged.
  - Host write to an address the stream reads on the same edge: the stream gets the old value.
  - Host writes during a stream are legal.
- Reset mid-stream: every output returns to its reset value on the next edge. No done pulse is generated.

## Timing
- start sampled at edge k: ptr loaded at k, first RAM read at k+1, entry in FIFO and m_valid=1 after k+2.
- Throughput: 1 entry per cycle with m_ready held high.
- END_CODE at address a: its read returns at edge t. After the last prior entry transfers, done pulses and busy falls on the same edge.
- Empty list (END_CODE at start_addr): done after k+3; count=0; m_valid never asserted.
- abort at edge j: m_valid=0, busy=0, done=1 after j.

## Structure
- Package init_store_pkg holds:
  - the status encoding (NONE/END/RANOUT/ABORT);
  - the default END_CODE;
  - the entry field slice constants DEV/REG/VAL.
- Sub-module ram_sdp_init: parametrised two-port block RAM.
  - Port A: read/write. Port B: read-only.
  - INIT_FILE attribute; ramstyle M9K; old-data read-during-write.
- The FSM, FIFO and credit logic live in the top level.

## Test plan
- Host write 0xABCDEF to address 5, then read address 5 → host_rdata=0xABCDEF one cycle later; same-edge read returns the prior value.
- Preload entries 0..3 = 0x981001..0x981004 and entry 4 = END_CODE; start at 0 with m_ready=1 → four consecutive beats from edge k+2, done, status=END, count=4.
- Same list with m_ready toggling 1,0,0,1 → no lost or duplicated entries, m_data stable while stalled, count=4.
- start_addr=62 with no END_CODE above → entries 62 and 63 delivered, then status=RANOUT, count=2.
- abort two cycles after the first beat with m_ready=0 → m_valid drops, done pulses, status=ABORT; a restart from 0 delivers the list again.
- rst asserted mid-stream → all outputs at reset values; host read of address 1 still returns 0x981002.
